// File: rtl/matrix_stream_loader_3x3_pkg.sv
// Shared constants for the 3x3 matrix stream loader: state encodings and frame geometry.
package matrix_stream_loader_3x3_pkg;

    localparam int unsigned M_DEF     = 3;
    localparam int unsigned P_DEF     = 3;
    localparam int unsigned MAT_SIZE  = M_DEF * P_DEF;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned FRAME_LEN = 2 * MAT_SIZE;

    localparam logic [1:0] S_LOAD_A = 2'd0;
    localparam logic [1:0] S_LOAD_B = 2'd1;
    localparam logic [1:0] S_START  = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

endpackage

// File: rtl/matrix_stream_loader_3x3.sv
// Stream feeder for the 3x3 add/sub calculator: loads A then B from a valid/ready stream,
// starts the calculator and waits for done, with frame length and timeout checking.
module matrix_stream_loader_3x3
    import matrix_stream_loader_3x3_pkg::*;
#(
    parameter int unsigned M          = M_DEF,
    parameter int unsigned P          = P_DEF,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    input  logic                  op_in,
    output logic [DATA_WIDTH-1:0] a_in,
    output logic [ADDR_W-1:0]     a_addr,
    output logic                  a_wen,
    output logic [DATA_WIDTH-1:0] b_in,
    output logic [ADDR_W-1:0]     b_addr,
    output logic                  b_wen,
    output logic                  start,
    output logic                  op,
    input  logic                  calc_done,
    output logic                  busy,
    output logic                  load_err,
    output logic                  calc_timeout,
    output logic [7:0]            frame_count
);

    localparam int unsigned MAT    = M * P;
    localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAT - 1);
    localparam logic [WCNT_W-1:0] TMO_LAST = WCNT_W'(TIMEOUT - 1);

    logic [1:0]            state_q, state_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0] a_in_q, a_in_d, b_in_q, b_in_d;
    logic [ADDR_W-1:0]     a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic                  a_wen_q, a_wen_d, b_wen_q, b_wen_d;
    logic                  start_q, start_d;
    logic                  op_q, op_d;
    logic                  busy_q, busy_d;
    logic                  load_err_q, load_err_d;
    logic                  tmo_q, tmo_d;
    logic [7:0]            fc_q, fc_d;
    logic                  accept;

    // Ready is decoded from the state register alone so it never depends on s_valid.
    assign s_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wcnt_d     = wcnt_q;
        a_in_d     = a_in_q;
        a_addr_d   = a_addr_q;
        a_wen_d    = 1'b0;
        b_in_d     = b_in_q;
        b_addr_d   = b_addr_q;
        b_wen_d    = 1'b0;
        start_d    = 1'b0;
        op_d       = op_q;
        busy_d     = busy_q;
        load_err_d = 1'b0;
        tmo_d      = 1'b0;
        fc_d       = fc_q;

        unique case (state_q)
            S_LOAD_A: begin
                if (accept) begin
                    if (s_last) begin
                        // Early end of frame: drop the beat and restart.
                        load_err_d = 1'b1;
                        busy_d     = 1'b0;
                        idx_d      = '0;
                    end else begin
                        a_in_d   = s_data;
                        a_addr_d = idx_q;
                        a_wen_d  = 1'b1;
                        if (idx_q == '0) begin
                            op_d   = op_in;
                            busy_d = 1'b1;
                        end
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = S_LOAD_B;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            S_LOAD_B: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        b_in_d   = s_data;
                        b_addr_d = idx_q;
                        b_wen_d  = 1'b1;
                        idx_d    = '0;
                        if (s_last) begin
                            state_d = S_START;
                        end else begin
                            load_err_d = 1'b1;
                            busy_d     = 1'b0;
                            state_d    = S_LOAD_A;
                        end
                    end else if (s_last) begin
                        load_err_d = 1'b1;
                        busy_d     = 1'b0;
                        idx_d      = '0;
                        state_d    = S_LOAD_A;
                    end else begin
                        b_in_d   = s_data;
                        b_addr_d = idx_q;
                        b_wen_d  = 1'b1;
                        idx_d    = idx_q + 1'b1;
                    end
                end
            end
            S_START: begin
                start_d = 1'b1;
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done takes priority over a coincident timeout.
                if (calc_done) begin
                    fc_d    = fc_q + 8'd1;
                    busy_d  = 1'b0;
                    state_d = S_LOAD_A;
                end else if (wcnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_LOAD_A;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: state_d = S_LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD_A;
            idx_q      <= '0;
            wcnt_q     <= '0;
            a_in_q     <= '0;
            a_addr_q   <= '0;
            a_wen_q    <= 1'b0;
            b_in_q     <= '0;
            b_addr_q   <= '0;
            b_wen_q    <= 1'b0;
            start_q    <= 1'b0;
            op_q       <= 1'b0;
            busy_q     <= 1'b0;
            load_err_q <= 1'b0;
            tmo_q      <= 1'b0;
            fc_q       <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wcnt_q     <= wcnt_d;
            a_in_q     <= a_in_d;
            a_addr_q   <= a_addr_d;
            a_wen_q    <= a_wen_d;
            b_in_q     <= b_in_d;
            b_addr_q   <= b_addr_d;
            b_wen_q    <= b_wen_d;
            start_q    <= start_d;
            op_q       <= op_d;
            busy_q     <= busy_d;
            load_err_q <= load_err_d;
            tmo_q      <= tmo_d;
            fc_q       <= fc_d;
        end
    end

    assign a_in         = a_in_q;
    assign a_addr       = a_addr_q;
    assign a_wen        = a_wen_q;
    assign b_in         = b_in_q;
    assign b_addr       = b_addr_q;
    assign b_wen        = b_wen_q;
    assign start        = start_q;
    assign op           = op_q;
    assign busy         = busy_q;
    assign load_err     = load_err_q;
    assign calc_timeout = tmo_q;
    assign frame_count  = fc_q;

endmodule

// File: tb/tb_matrix_stream_loader_3x3.sv
// Bench for the stream loader with a behavioural 3x3 add/sub calculator on its write ports.
module tb_matrix_stream_loader_3x3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_last = 1'b0;
    logic        op_in = 1'b0;
    logic [31:0] a_in, b_in;
    logic [3:0]  a_addr, b_addr;
    logic        a_wen, b_wen, start, op;
    logic        calc_done = 1'b0;
    logic        busy, load_err, calc_timeout;
    logic [7:0]  frame_count;

    always #5 clk = ~clk;

    matrix_stream_loader_3x3 dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_last       (s_last),
        .op_in        (op_in),
        .a_in         (a_in),
        .a_addr       (a_addr),
        .a_wen        (a_wen),
        .b_in         (b_in),
        .b_addr       (b_addr),
        .b_wen        (b_wen),
        .start        (start),
        .op           (op),
        .calc_done    (calc_done),
        .busy         (busy),
        .load_err     (load_err),
        .calc_timeout (calc_timeout),
        .frame_count  (frame_count)
    );

    int n_chk = 0;
    int n_err = 0;
    int exp_q[$];
    int a_mem[16];
    int b_mem[16];
    int cyc = 0, n_awen = 0, n_bwen = 0, n_start = 0, n_lerr = 0, n_tmo = 0, n_nrdy = 0;
    int last_bwen_cyc = 0, start_cyc = 0, tmo_cyc = 0, calc_cnt = 0, res = 0;
    logic calc_run = 1'b0, calc_op = 1'b0, hang = 1'b0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_awen = 0; n_bwen = 0; n_start = 0; n_lerr = 0; n_tmo = 0; n_nrdy = 0;
    endtask

    // Calculator model: latches writes, answers start after a few cycles with nine results.
    always @(negedge clk) begin
        cyc++;
        calc_done = 1'b0;
        if (a_wen) begin a_mem[a_addr] = a_in; n_awen++; end
        if (b_wen) begin b_mem[b_addr] = b_in; n_bwen++; last_bwen_cyc = cyc; end
        if (!s_ready) n_nrdy++;
        if (load_err) n_lerr++;
        if (calc_timeout) begin n_tmo++; tmo_cyc = cyc; end
        if (start) begin
            n_start++;
            start_cyc = cyc;
            check_eq("start_gap", cyc - last_bwen_cyc, 1);
            calc_cnt = 3;
            calc_op  = op;
            calc_run = 1'b1;
        end else if (calc_run) begin
            calc_cnt--;
            if (calc_cnt == 0) begin
                calc_run = 1'b0;
                if (!hang) begin
                    for (int k = 0; k < 9; k++) begin
                        res = calc_op ? a_mem[k] - b_mem[k] : a_mem[k] + b_mem[k];
                        if (exp_q.size() == 0) check_eq("result_extra", 0, 1);
                        else check_eq("result", res, exp_q.pop_front());
                    end
                    calc_done = 1'b1;
                end
            end
        end
    end

    task automatic send_beat(input int data, input logic last, input logic opv);
        int guard = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        op_in   = opv;
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) check_eq("beat_stall", s_ready, 1);
    endtask

    task automatic send_frame(input int n, input int last_at, input logic opv, input logic gap,
                              input logic push);
        for (int i = 1; i <= n; i++) begin
            if (gap && i > 1) begin
                @(negedge clk);
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            send_beat((i <= 9) ? i : 19 - i, i == last_at, opv);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (push) for (int k = 0; k < 9; k++) exp_q.push_back(opv ? (k + 1) - (9 - k) : 10);
    endtask

    task automatic wait_fc(input int target);
        for (int i = 0; i < 200 && frame_count != 8'(target); i++) @(negedge clk);
        check_eq("frame_count", frame_count, target);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_s_ready", s_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_fc", frame_count, 0);
        check_eq("rst_start", start, 0);
        check_eq("rst_a_wen", a_wen, 0);
        rst = 1'b0;

        // Add frame, continuous valid
        clear_counts();
        send_frame(18, 18, 1'b0, 1'b0, 1'b1);
        check_eq("t1_busy_mid", busy, 1);
        wait_fc(1);
        check_eq("t1_awen", n_awen, 9);
        check_eq("t1_bwen", n_bwen, 9);
        check_eq("t1_start", n_start, 1);
        check_eq("t1_nrdy", n_nrdy, 5);
        check_eq("t1_busy", busy, 0);
        check_eq("t1_q_empty", exp_q.size(), 0);

        // Sub frame, valid toggling
        clear_counts();
        send_frame(18, 18, 1'b1, 1'b1, 1'b1);
        check_eq("t2_op_mid", op, 1);
        wait_fc(2);
        check_eq("t2_op", op, 1);
        check_eq("t2_nrdy", n_nrdy, 5);
        check_eq("t2_start", n_start, 1);
        check_eq("t2_q_empty", exp_q.size(), 0);

        // Early s_last on beat 12, then a good frame
        clear_counts();
        send_frame(12, 12, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("t3_lerr", n_lerr, 1);
        check_eq("t3_start", n_start, 0);
        check_eq("t3_busy", busy, 0);
        check_eq("t3_awen", n_awen, 9);
        check_eq("t3_bwen", n_bwen, 2);
        send_frame(18, 18, 1'b0, 1'b0, 1'b1);
        wait_fc(3);
        check_eq("t3_q_empty", exp_q.size(), 0);

        // 18 beats, no s_last
        clear_counts();
        send_frame(18, 0, 1'b0, 1'b0, 1'b0);
        check_eq("t4_ready_next", s_ready, 1);
        repeat (2) @(negedge clk);
        check_eq("t4_lerr", n_lerr, 1);
        check_eq("t4_start", n_start, 0);
        check_eq("t4_busy", busy, 0);

        // Calculator never answers
        hang = 1'b1;
        clear_counts();
        send_frame(18, 18, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 200 && n_tmo == 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_eq("t5_tmo", n_tmo, 1);
        check_eq("t5_tmo_delay", tmo_cyc - start_cyc, 64);
        check_eq("t5_fc", frame_count, 3);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_ready", s_ready, 1);
        hang = 1'b0;

        // Async reset after beat 5
        clear_counts();
        send_frame(5, 0, 1'b0, 1'b0, 1'b0);
        check_eq("t6_a_wen_pre", a_wen, 1);
        #1 rst = 1'b1;
        #1;
        check_eq("t6_a_wen", a_wen, 0);
        check_eq("t6_a_addr", a_addr, 0);
        check_eq("t6_a_in", a_in, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_fc", frame_count, 0);
        check_eq("t6_op", op, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_counts();
        send_frame(18, 18, 1'b1, 1'b0, 1'b1);
        wait_fc(1);
        check_eq("t6_start", n_start, 1);
        check_eq("t6_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
